vid_dtack_gen: RTL and testbench

VID_DTACK_GEN -- requirements
Module: vid_dtack_gen

---
 rtl/vid_dtack_gen_if.sv | 27 ++
 rtl/vid_dtack_gen.sv | 174 +++++++++++++++++
 tb/tb_vid_dtack_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_dtack_gen_if.sv
// Bus bundle between the CPU-side strobe logic and the video DTACK generator.
interface vid_dtack_gen_if #(
    parameter int CHANNELS = 2,
    parameter int WAIT_W   = 4
);
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                       ce_pq;
    logic                       PDS;
    logic [CHANNELS-1:0]        nCS;
    logic [CHANNELS*WAIT_W-1:0] wait_cfg;
    logic                       hold;
    logic                       VDTAC;
    logic                       nBERR;
    logic                       busy;
    logic [AW-1:0]              active_ch;

    modport master (
        output ce_pq, PDS, nCS, wait_cfg, hold,
        input  VDTAC, nBERR, busy, active_ch
    );

    modport slave (
        input  ce_pq, PDS, nCS, wait_cfg, hold,
        output VDTAC, nBERR, busy, active_ch
    );
endinterface

// File: rtl/vid_dtack_gen.sv
// Video chip-select DTACK generator: phase-aligned, per-channel wait states, hold extension.
// Optional bus-error timeout enabled by defining DTACK_TIMEOUT_EN.
module vid_dtack_gen #(
    parameter int CHANNELS = 2,
    parameter int WAIT_W   = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic           clk_main,
    input  logic           reset,
    vid_dtack_gen_if.slave bus
);
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    if (CHANNELS < 1 || CHANNELS > 8 || WAIT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("vid_dtack_gen: parameter out of range");
    end

    // Lowest-index active-low select wins.
    function automatic logic [AW-1:0] lowest_sel(input logic [CHANNELS-1:0] ncs);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (!ncs[i]) begin
                idx = AW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t              state_r, state_n;
    logic [WAIT_W-1:0]   cnt_r, cnt_n;
    logic [AW-1:0]       active_ch_r, ch_n;
    logic                vdtac_r, vdtac_n;
    logic                nberr_r, nberr_n;
    logic                busy_r;
    logic                any_sel_s;
    logic [WAIT_W-1:0]   sel_wait_s;
    logic                timeout_hit_s;

    assign any_sel_s = ~&bus.nCS;

    // Wait count of the latched channel.
    always_comb begin
        sel_wait_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (active_ch_r == AW'(i)) begin
                sel_wait_s = bus.wait_cfg[i*WAIT_W +: WAIT_W];
            end else begin
                sel_wait_s = sel_wait_s;
            end
        end
    end

`ifdef DTACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_r, to_cnt_n;

    assign timeout_hit_s = (to_cnt_r == TW'(TIMEOUT - 1));

    // Timeout counter next value: cleared on SYNC entry, counts while a cycle is pending.
    always_comb begin
        to_cnt_n = to_cnt_r;
        if (state_r == ST_IDLE && state_n == ST_SYNC) begin
            to_cnt_n = '0;
        end else if (state_r == ST_SYNC || state_r == ST_WAIT) begin
            to_cnt_n = to_cnt_r + TW'(1);
        end else begin
            to_cnt_n = to_cnt_r;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_n;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        ch_n    = active_ch_r;
        vdtac_n = 1'b1;
        nberr_n = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (!bus.PDS && any_sel_s) begin
                    ch_n    = lowest_sel(bus.nCS);
                    state_n = ST_SYNC;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (bus.PDS) begin
                    state_n = ST_IDLE;
                end else if (timeout_hit_s) begin
                    state_n = ST_ACK;
                    nberr_n = 1'b0;
                end else if (bus.ce_pq) begin
                    cnt_n   = sel_wait_s;
                    state_n = ST_WAIT;
                end else begin
                    state_n = ST_SYNC;
                end
            end
            ST_WAIT: begin
                if (bus.PDS) begin
                    state_n = ST_IDLE;
                end else if (!bus.hold && cnt_r == '0) begin
                    state_n = ST_ACK;
                    vdtac_n = 1'b0;
                end else if (timeout_hit_s) begin
                    state_n = ST_ACK;
                    nberr_n = 1'b0;
                end else if (bus.hold) begin
                    cnt_n = cnt_r;
                end else begin
                    cnt_n = cnt_r - WAIT_W'(1);
                end
            end
            ST_ACK: begin
                if (bus.PDS) begin
                    state_n = ST_IDLE;
                end else begin
                    vdtac_n = vdtac_r;
                    nberr_n = nberr_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            active_ch_r <= '0;
            vdtac_r     <= 1'b1;
            nberr_r     <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            active_ch_r <= ch_n;
            vdtac_r     <= vdtac_n;
            nberr_r     <= nberr_n;
            busy_r      <= (state_n != ST_IDLE);
        end
    end

    assign bus.VDTAC     = vdtac_r;
    assign bus.nBERR     = nberr_r;
    assign bus.busy      = busy_r;
    assign bus.active_ch = active_ch_r;
endmodule

// File: tb/tb_vid_dtack_gen.sv
// Directed, table-driven bench for vid_dtack_gen (CHANNELS=2, WAIT_W=4, TIMEOUT=64).
module tb_vid_dtack_gen;
    logic clk_main = 1'b0;
    logic reset    = 1'b1;
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   inv_bad  = 0;

    vid_dtack_gen_if #(.CHANNELS(2), .WAIT_W(4)) bus ();

    vid_dtack_gen #(.CHANNELS(2), .WAIT_W(4), .TIMEOUT(64)) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk_main = ~clk_main;

    always @(negedge clk_main) begin
        if (bus.VDTAC === 1'b0 && bus.nBERR === 1'b0) inv_bad++;
    end

    typedef struct {
        string      name;
        logic       ce;
        logic       pds;
        logic [1:0] ncs;
        logic       exp_v;
        logic       exp_busy;
        logic       exp_ch;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string n, logic ce, logic pds, logic [1:0] ncs,
                                logic ev, logic eb, logic ech);
        vec_t v;
        v.name = n; v.ce = ce; v.pds = pds; v.ncs = ncs;
        v.exp_v = ev; v.exp_busy = eb; v.exp_ch = ech;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic drive(input logic ce, input logic pds, input logic [1:0] ncs, input logic hold);
        bus.ce_pq = ce;
        bus.PDS   = pds;
        bus.nCS   = ncs;
        bus.hold  = hold;
    endtask

    task automatic check_out(input string nm, input logic ev, input logic eb,
                             input logic ech, input logic en);
        n_vec++;
        if (bus.VDTAC !== ev || bus.busy !== eb || bus.active_ch !== ech || bus.nBERR !== en) begin
            n_bad++;
            $display("FAIL %s: got VDTAC=%b busy=%b ch=%0d nBERR=%b, expected VDTAC=%b busy=%b ch=%0d nBERR=%b",
                     nm, bus.VDTAC, bus.busy, bus.active_ch, bus.nBERR, ev, eb, ech, en);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Starting in SYNC: pulse ce_pq (edge k), optionally rewrite wait_cfg, hold for
    // edges k+1..k+hold_len, and return how many edges after k VDTAC falls (-1 if never).
    task automatic run_wait(input int hold_len, input logic [7:0] cfg_after, output int edges);
        edges = -1;
        bus.ce_pq = 1'b1;
        tick();
        bus.ce_pq    = 1'b0;
        bus.wait_cfg = cfg_after;
        for (int n = 1; n <= 40; n++) begin
            bus.hold = (n <= hold_len);
            tick();
            if (bus.VDTAC === 1'b0) begin
                edges = n;
                break;
            end
        end
        bus.hold = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int bad;

        drive(1'b0, 1'b1, 2'b11, 1'b0);
        bus.wait_cfg = {4'd0, 4'd3};
        repeat (3) @(posedge clk_main);
        #1;
        check_out("reset_state", 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;

        tbl.push_back(mk("idle",        1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("sel_ch0",     1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("sync_stay",   1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("ce_load",     1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("wait_2",      1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("wait_1",      1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("wait_0",      1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("ack_k4",      1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("ncs_off_hold",1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("pds_up_end",  1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("pds_hi_nostart",1'b0,1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("both_sel",    1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("both_ce",     1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("both_w2",     1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("both_w1",     1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("both_w0",     1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("both_ack",    1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("both_end",    1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("ch1_sel",     1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk("ch1_ce",      1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk("ch1_ack_n0",  1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk("ch1_end",     1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk("abw_sel",     1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("abw_ce",      1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("abw_cnt2",    1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("abw_pds",     1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("abw_idle",    1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("abs_sel",     1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk("abs_pds",     1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk("ce_in_idle",  1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("ce_after",    1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("ce_real",     1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("late_w2",     1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("late_w1",     1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("late_w0",     1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk("late_ack",    1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk("late_end",    1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ce, tbl[i].pds, tbl[i].ncs, 1'b0);
            tick();
            check_out(tbl[i].name, tbl[i].exp_v, tbl[i].exp_busy, tbl[i].exp_ch, 1'b1);
        end

        // Channel 1 with two wait states: plain, with 5-cycle hold, and with wait_cfg rewritten after load.
        bus.wait_cfg = {4'd2, 4'd3};
        drive(1'b0, 1'b0, 2'b01, 1'b0);
        tick();
        run_wait(0, {4'd2, 4'd3}, edges);
        check_int("lat_ch1_nohold", edges, 3);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        check_out("lat_ch1_end", 1'b1, 1'b0, 1'b1, 1'b1);

        drive(1'b0, 1'b0, 2'b01, 1'b0);
        tick();
        run_wait(5, {4'd2, 4'd3}, edges);
        check_int("lat_ch1_hold5", edges, 8);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();

        drive(1'b0, 1'b0, 2'b01, 1'b0);
        tick();
        run_wait(0, {4'd15, 4'd15}, edges);
        check_int("cfg_after_load", edges, 3);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        bus.wait_cfg = {4'd0, 4'd3};

        // Asynchronous reset while acknowledging.
        drive(1'b0, 1'b0, 2'b10, 1'b0);
        tick();
        run_wait(0, {4'd0, 4'd3}, edges);
        check_out("pre_reset_ack", 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_out("async_reset", 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_out("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 2'b10, 1'b0);
        tick();
        run_wait(0, {4'd0, 4'd3}, edges);
        check_int("post_reset_lat", edges, 4);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();

`ifdef DTACK_TIMEOUT_EN
        drive(1'b0, 1'b0, 2'b10, 1'b1);
        tick();
        edges = -1;
        for (int n = 1; n <= 200; n++) begin
            bus.ce_pq = (n == 1);
            tick();
            if (bus.nBERR === 1'b0) begin
                edges = n;
                break;
            end
        end
        check_int("timeout_edges", edges, 64);
        check_out("timeout_berr", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 2'b10, 1'b0);
        tick();
        check_out("timeout_held", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        check_out("timeout_end", 1'b1, 1'b0, 1'b0, 1'b1);
`else
        drive(1'b0, 1'b0, 2'b10, 1'b1);
        tick();
        bus.ce_pq = 1'b1;
        tick();
        bus.ce_pq = 1'b0;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (bus.VDTAC !== 1'b1 || bus.nBERR !== 1'b1 || bus.busy !== 1'b1) bad++;
        end
        check_int("hold_nolimit", bad, 0);
        bus.hold = 1'b0;
        edges = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.VDTAC === 1'b0) begin
                edges = n;
                break;
            end
        end
        check_int("hold_release_lat", edges, 4);
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        tick();
        check_out("hold_end", 1'b1, 1'b0, 1'b0, 1'b1);
`endif

        check_int("vdtac_nberr_exclusive", inv_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
